// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM port arbiter.
// State encoding, data-mask constants, command encodings and a small helper.
package psram_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StWait = 2'd2
    } psram_state_e;

    localparam logic [3:0] MASK_NONE    = 4'b1111;
    localparam logic [3:0] MASK_HI_WORD = 4'b0011;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the port after the last winner.
// The pointer moves only when the caller signals that the grant was taken.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] win;
    logic [PW-1:0] nxt;
    logic          found;
    int unsigned   idx;

    always_comb begin
        grant = '0;
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[PW'(idx)]) begin
                grant[PW'(idx)] = 1'b1;
                win             = PW'(idx);
                found           = 1'b1;
            end
        end
    end

    always_comb begin
        nxt = win + 1'b1;
        if (32'(win) == N - 1) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= nxt;
        end
    end

endmodule

// File: rtl/psram_port_arb.sv
// Multi-port arbiter in front of a PSRAM controller: one transaction in flight at a time.
// Optional read-data timeout is enabled by defining PSRAM_TIMEOUT_EN.
module psram_port_arb
    import psram_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned RD_GAP = 13,
    parameter int unsigned WR_GAP = 13,
    parameter int unsigned TMO    = 64
) (
    input  logic                        clk_out,
    input  logic                        rst_n,
    input  logic                        init_calib,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0]             req_we,
    input  logic [NREQ-1:0]             req_byte,
    input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0][15:0]       req_wdata,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [15:0]                 rsp_rdata,
    output logic                        cmd,
    output logic                        cmd_en,
    output logic [ADDR_W-2:0]           addr,
    output logic [31:0]                 wr_data,
    output logic [3:0]                  data_mask,
    input  logic [31:0]                 rd_data,
    input  logic                        rd_data_valid
`ifdef PSRAM_TIMEOUT_EN
    ,
    output logic                        rd_timeout
`endif
);

    localparam int unsigned GAP_MAX = max_u(max_u(RD_GAP, WR_GAP), 1);
    localparam int unsigned CNT_W   = $clog2(GAP_MAX + 1);
    localparam logic [CNT_W-1:0] RD_END  = CNT_W'(RD_GAP);
    localparam logic [CNT_W-1:0] WR_END  = CNT_W'(WR_GAP);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(GAP_MAX);

    psram_state_e state_q, state_d;

    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   owner_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic              accept;
    logic              sel_we, sel_byte;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic              we_q, byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [15:0]       rsp_rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              beat_q;
    logic              rd_hit, tmo_hit, cap, done;
    logic [15:0]       cap_data;
    logic [15:0]       unused_rd_lo;

    assign unused_rd_lo = rd_data[15:0];

    assign accept = (state_q == StIdle) && init_calib && (|req_valid);

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk     (clk_out),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Gated by rst_n so the grant is forced low while reset is held.
    assign req_ready = (accept && rst_n) ? grant : '0;

    always_comb begin
        sel_we    = 1'b0;
        sel_byte  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_we    = req_we[i];
                sel_byte  = req_byte[i];
                sel_addr  = req_addr[i];
                sel_wdata = req_wdata[i];
            end
        end
    end

    assign rd_hit = (state_q == StWait) && !we_q && !beat_q && rd_data_valid;
    assign cap      = rd_hit || tmo_hit;
    assign cap_data = rd_hit ? rd_data[31:16] : 16'hFFFF;

    assign done = (state_q == StWait) &&
                  (we_q ? (cnt_q == WR_END) : ((cnt_q >= RD_END) && beat_q));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StCmd;
            StCmd:   state_d = StWait;
            StWait:  if (done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            beat_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= '0;
            if (accept) begin
                owner_q <= grant;
                we_q    <= sel_we;
                byte_q  <= sel_byte;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state_q == StCmd) begin
                cnt_q  <= '0;
                beat_q <= 1'b0;
            end else if ((state_q == StWait) && (cnt_q != CNT_SAT)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Only the first beat of a burst is kept; later beats see beat_q set.
            if (cap) begin
                beat_q      <= 1'b1;
                rsp_rdata_q <= cap_data;
                rsp_valid_q <= owner_q;
            end
        end
    end

`ifdef PSRAM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_END = TW'(TMO);

    logic [TW-1:0] tmo_q;
    logic          rd_timeout_q;

    // tmo_q counts cycles elapsed since the cmd_en cycle.
    assign tmo_hit = (state_q == StWait) && !we_q && !beat_q && !rd_data_valid &&
                     (tmo_q == TMO_END);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q        <= '0;
            rd_timeout_q <= 1'b0;
        end else begin
            if (state_q == StCmd) begin
                tmo_q <= TW'(1);
            end else if ((state_q == StWait) && (tmo_q != TMO_END)) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (tmo_hit) begin
                rd_timeout_q <= 1'b1;
            end
        end
    end

    assign rd_timeout = rd_timeout_q;
`else
    logic [31:0] unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = 32'(TMO);
`endif

    assign cmd_en    = (state_q == StCmd);
    assign cmd       = we_q ? CMD_WR : CMD_RD;
    assign addr      = addr_q[ADDR_W-1:1];
    assign wr_data   = {wdata_q, 16'h0000};
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        data_mask = MASK_NONE;
        if (state_q == StCmd && we_q) begin
            data_mask = byte_q ? {~addr_q[0], addr_q[0], 2'b11} : MASK_HI_WORD;
        end
    end

endmodule
